sys_req_arbiter: RTL

- Shares the system-to-decoder DRAM request port (req/rdwr/addr/wr_data) among NUM_REQ requesters.
- Uses round-robin arbitration with registered outputs and honours the controller's busy backpressure.
- Keeps an in-order FIFO of requester IDs for outstanding reads, so read completions route back to their issuer.
- Sits between the CPU-side masters and the decoder's input FIFO.

---
 rtl/sys_req_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sys_req_arbiter.sv
// sys_req_arbiter
// Purpose : round-robin sharing of the system-to-decoder DRAM request port
//           among NUM_REQ requesters. The winning request is registered and
//           presented as a one-cycle strobe on the following cycle. Requester
//           IDs of issued reads are queued in order, so each read completion
//           is routed back to the requester that issued it.
// Ports   : clk, reset (async, active low)
//           req/req_rdwr/req_addr/req_wr_data   - per-requester request inputs
//           gnt                                 - one-hot grant, same cycle as request
//           sys__mc__dram_*                     - registered strobe + payload to decoder
//           mc__sys__dram_busy                  - decoder backpressure
//           mc__sys__dram_rd_done/_rd_data      - read completion from controller
//           rd_done/rd_data                     - routed completion to requesters
//           rd_err                              - sticky completion-without-read flag
// Option  : define SYS_ARB_STALL_CNT_EN to add stall_cnt[15:0], a saturating
//           count of cycles with a pending request but no grant.
module sys_req_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int RD_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rdwr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      sys__mc__dram_req,
    output logic                      sys__mc__dram_rdwr,
    output logic [ADDR_W-1:0]         sys__mc__dram_addr,
    output logic [DATA_W-1:0]         sys__mc__dram_wr_data,
    input  logic                      mc__sys__dram_busy,
    input  logic                      mc__sys__dram_rd_done,
    input  logic [DATA_W-1:0]         mc__sys__dram_rd_data,
    output logic [NUM_REQ-1:0]        rd_done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err
`ifdef SYS_ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam int CNT_W = $clog2(RD_DEPTH + 1);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    win_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] elig;
    logic               fifo_full;

    logic               dram_req_q, dram_rdwr_q;
    logic [ADDR_W-1:0]  dram_addr_q;
    logic [DATA_W-1:0]  dram_wr_data_q;

    logic [ID_W-1:0]    id_mem [RD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;

    logic [NUM_REQ-1:0] rd_done_q, rd_done_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_err_q;

    // Full test uses the registered count only; a pop in the same cycle does
    // not free a slot until the next cycle.
    assign fifo_full = (count_q == CNT_W'(RD_DEPTH));

    // Eligibility is gated by reset so the combinational grant is also
    // forced low while reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign elig[gi] = reset && req[gi] && !mc__sys__dram_busy &&
                              (!req_rdwr[gi] || !fifo_full);
            assign gnt[gi]  = grant_any && (win_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from ptr upward; iterating from the farthest offset down makes the
    // nearest eligible index the last (winning) assignment.
    always_comb begin
        int idx;
        win_idx   = '0;
        grant_any = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (elig[idx]) begin
                win_idx   = ID_W'(idx);
                grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign push = grant_any && req_rdwr[win_idx];
    assign pop  = mc__sys__dram_rd_done && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_done_d = '0;
        if (pop) begin
            rd_done_d[id_mem[rd_ptr_q]] = 1'b1;
        end
    end

    // ID storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q] <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q          <= '0;
            dram_req_q     <= 1'b0;
            dram_rdwr_q    <= 1'b0;
            dram_addr_q    <= '0;
            dram_wr_data_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_done_q      <= '0;
            rd_data_q      <= '0;
            rd_err_q       <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            dram_req_q <= grant_any;
            if (grant_any) begin
                dram_rdwr_q    <= req_rdwr[win_idx];
                dram_addr_q    <= req_addr[win_idx*ADDR_W +: ADDR_W];
                dram_wr_data_q <= req_wr_data[win_idx*DATA_W +: DATA_W];
            end
            // Pointer width is log2(RD_DEPTH), so increments wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            rd_done_q <= rd_done_d;
            if (pop) rd_data_q <= mc__sys__dram_rd_data;
            if (mc__sys__dram_rd_done && (count_q == '0)) rd_err_q <= 1'b1;
        end
    end

    assign sys__mc__dram_req     = dram_req_q;
    assign sys__mc__dram_rdwr    = dram_rdwr_q;
    assign sys__mc__dram_addr    = dram_addr_q;
    assign sys__mc__dram_wr_data = dram_wr_data_q;
    assign rd_done               = rd_done_q;
    assign rd_data               = rd_data_q;
    assign rd_err                = rd_err_q;

`ifdef SYS_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((|req) && !grant_any && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
